// File: rtl/cp0_interrupt_unit_pkg.sv
// Shared CP0 register numbers, Status/Cause bit positions and timer MMIO addresses.
package cp0_interrupt_unit_pkg;

   localparam logic [4:0] CP0_STATUS = 5'd12;
   localparam logic [4:0] CP0_CAUSE  = 5'd13;
   localparam logic [4:0] CP0_EPC    = 5'd14;

   localparam int IE_BIT   = 0;
   localparam int EXL_BIT  = 1;
   localparam int IM_LSB   = 8;
   localparam int IM_MSB   = 15;
   localparam int TIMER_IP = 7;

   // Memory-mapped timer counter and its interrupt acknowledge register.
   localparam logic [31:0] TIMER_ADDR     = 32'hffff001c;
   localparam logic [31:0] TIMER_ACK_ADDR = 32'hffff006c;

   typedef struct packed {
      logic [7:0] im;
      logic       exl;
      logic       ie;
   } status_t;

   function automatic logic [31:0] pack_status(input status_t s);
      logic [31:0] r;
      r = '0;
      r[IM_MSB:IM_LSB] = s.im;
      r[EXL_BIT]       = s.exl;
      r[IE_BIT]        = s.ie;
      return r;
   endfunction

   function automatic logic [31:0] pack_cause(input logic [7:0] ip);
      logic [31:0] r;
      r = '0;
      r[IM_MSB:IM_LSB] = ip;
      return r;
   endfunction

endpackage

// File: rtl/cp0_interrupt_unit_reg.sv
// Width-parameterised load-enable flop with asynchronous active-low reset.
// One-cycle load latency; holds its value whenever load is low.
module cp0_reg #(
   parameter int             W       = 1,
   parameter logic [W-1:0]   RST_VAL = '0
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         q <= RST_VAL;
      else if (load)
         q <= d;
   end

endmodule

// File: rtl/cp0_interrupt_unit.sv
// CP0 Status/Cause/EPC with interrupt take/eret priority logic and mfc0 read mux.
// TakenInterrupt and rd_data are combinational; register updates land on the next clock edge.
module cp0_interrupt_unit
   import cp0_interrupt_unit_pkg::*;
#(
   parameter int PC_WIDTH  = 30,
   parameter int EXT_LINES = 7
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [31:0]          wr_data,
   input  logic [4:0]           regnum,
   input  logic [PC_WIDTH-1:0]  next_pc,
   input  logic                 MTC0,
   input  logic                 ERET,
   input  logic                 TimerInterrupt,
   input  logic [EXT_LINES-1:0] ExtInterrupt,
   output logic [31:0]          rd_data,
   output logic [PC_WIDTH-1:0]  EPC,
   output logic                 TakenInterrupt
);

   logic [7:0]          im_q, im_d;
   logic                exl_q, exl_d, ie_q, ie_d;
   logic [PC_WIDTH-1:0] epc_d;
   logic                im_ld, exl_ld, ie_ld, epc_ld;
   logic [6:0]          ext7;
   logic [7:0]          ip;
   logic                wr_status, wr_epc;
   status_t             status;

   always_comb begin
      ext7 = '0;
      ext7[EXT_LINES-1:0] = ExtInterrupt;
   end

   assign ip = {TimerInterrupt, ext7};

   assign TakenInterrupt = (|(ip & im_q)) & ie_q & ~exl_q;

   assign wr_status = MTC0 && (regnum == CP0_STATUS);
   assign wr_epc    = MTC0 && (regnum == CP0_EPC);

   // Taking an interrupt swallows any same-cycle mtc0; eret only overrides EXL.
   always_comb begin
      im_d   = wr_data[IM_MSB:IM_LSB];
      ie_d   = wr_data[IE_BIT];
      exl_d  = wr_data[EXL_BIT];
      epc_d  = wr_data[PC_WIDTH+1:2];
      im_ld  = 1'b0;
      ie_ld  = 1'b0;
      exl_ld = 1'b0;
      epc_ld = 1'b0;
      if (TakenInterrupt) begin
         exl_ld = 1'b1;
         exl_d  = 1'b1;
         epc_ld = 1'b1;
         epc_d  = next_pc;
      end else if (ERET) begin
         exl_ld = 1'b1;
         exl_d  = 1'b0;
         im_ld  = wr_status;
         ie_ld  = wr_status;
      end else begin
         im_ld  = wr_status;
         ie_ld  = wr_status;
         exl_ld = wr_status;
         epc_ld = wr_epc;
      end
   end

   cp0_reg #(.W(8)) u_im (
      .clock (clock), .reset (reset), .load (im_ld), .d (im_d), .q (im_q)
   );

   cp0_reg #(.W(1)) u_exl (
      .clock (clock), .reset (reset), .load (exl_ld), .d (exl_d), .q (exl_q)
   );

   cp0_reg #(.W(1)) u_ie (
      .clock (clock), .reset (reset), .load (ie_ld), .d (ie_d), .q (ie_q)
   );

   cp0_reg #(.W(PC_WIDTH)) u_epc (
      .clock (clock), .reset (reset), .load (epc_ld), .d (epc_d), .q (EPC)
   );

   always_comb begin
      status.im  = im_q;
      status.exl = exl_q;
      status.ie  = ie_q;
      case (regnum)
         CP0_STATUS: rd_data = pack_status(status);
         CP0_CAUSE:  rd_data = pack_cause(ip);
         CP0_EPC:    rd_data = 32'({EPC, 2'b00});
         default:    rd_data = '0;
      endcase
   end

endmodule

// File: tb/tb_cp0_interrupt_unit.sv
// Directed bench for cp0_interrupt_unit with hand-computed expectations.
module tb_cp0_interrupt_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] wr_data;
   logic [4:0]  regnum;
   logic [29:0] next_pc;
   logic        MTC0, ERET, TimerInterrupt;
   logic [6:0]  ExtInterrupt;
   logic [31:0] rd_data;
   logic [29:0] EPC;
   logic        TakenInterrupt;

   int n_cmp = 0;
   int n_bad = 0;

   cp0_interrupt_unit #(.PC_WIDTH(30), .EXT_LINES(7)) dut (
      .clock          (clock),
      .reset          (reset),
      .wr_data        (wr_data),
      .regnum         (regnum),
      .next_pc        (next_pc),
      .MTC0           (MTC0),
      .ERET           (ERET),
      .TimerInterrupt (TimerInterrupt),
      .ExtInterrupt   (ExtInterrupt),
      .rd_data        (rd_data),
      .EPC            (EPC),
      .TakenInterrupt (TakenInterrupt)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic rd_chk(input string tag, input logic [4:0] rn, input logic [31:0] exp);
      regnum = rn;
      #1;
      chk(tag, rd_data, exp);
   endtask

   initial begin
      reset = 1'b0; wr_data = '0; regnum = '0; next_pc = '0;
      MTC0 = 0; ERET = 0; TimerInterrupt = 0; ExtInterrupt = '0;
      #3;
      rd_chk("rst_status", 5'd12, 32'h0);
      chk("rst_taken", {31'b0, TakenInterrupt}, 32'h0);
      chk("rst_epc", {2'b0, EPC}, 32'h0);
      reset = 1'b1;
      step();

      // Enable IM[7] and IE, then raise the timer.
      MTC0 = 1; regnum = 5'd12; wr_data = 32'h8001;
      step();
      MTC0 = 0;
      rd_chk("status_wr", 5'd12, 32'h8001);
      chk("no_irq_yet", {31'b0, TakenInterrupt}, 32'h0);
      next_pc = 30'h0040_0010; TimerInterrupt = 1;
      #1;
      chk("taken_same_cycle", {31'b0, TakenInterrupt}, 32'h1);
      step();
      rd_chk("status_exl", 5'd12, 32'h8003);
      rd_chk("epc_read", 5'd14, 32'h0100_0040);

      // Held timer while EXL=1 must not retrigger.
      next_pc = 30'h0000_0999;
      for (int i = 0; i < 10; i++) begin
         chk("hold_exl_taken", {31'b0, TakenInterrupt}, 32'h0);
         step();
      end
      chk("hold_epc", {2'b0, EPC}, 32'h0040_0010);

      ERET = 1;
      #1;
      chk("eret_cycle_taken", {31'b0, TakenInterrupt}, 32'h0);
      step();
      ERET = 0;
      rd_chk("eret_status", 5'd12, 32'h8001);
      chk("retrigger", {31'b0, TakenInterrupt}, 32'h1);

      // Interrupt beats a same-cycle mtc0 to EPC.
      next_pc = 30'h0000_0777; MTC0 = 1; regnum = 5'd14; wr_data = 32'hdeadbeef;
      step();
      MTC0 = 0;
      chk("epc_vs_mtc0", {2'b0, EPC}, 32'h0000_0777);
      rd_chk("status_exl2", 5'd12, 32'h8003);

      // mtc0 EPC while in handler, then async reset mid-handler.
      MTC0 = 1; regnum = 5'd14; wr_data = 32'h0000_048c;
      step();
      MTC0 = 0;
      chk("epc_mtc0", {2'b0, EPC}, 32'h0000_0123);
      #1;
      reset = 1'b0;
      #1;
      chk("async_epc", {2'b0, EPC}, 32'h0);
      rd_chk("async_status", 5'd12, 32'h0);
      chk("async_taken", {31'b0, TakenInterrupt}, 32'h0);
      TimerInterrupt = 0;
      step();
      reset = 1'b1;
      step();

      // IM only on external line 0; timer alone must not fire.
      MTC0 = 1; regnum = 5'd12; wr_data = 32'h0101;
      step();
      MTC0 = 0;
      TimerInterrupt = 1; ExtInterrupt = '0; next_pc = 30'h0000_0abc;
      rd_chk("cause_timer", 5'd13, 32'h8000);
      chk("masked_timer", {31'b0, TakenInterrupt}, 32'h0);
      ExtInterrupt = 7'h01;
      rd_chk("cause_ext", 5'd13, 32'h8100);
      chk("ext_taken", {31'b0, TakenInterrupt}, 32'h1);
      step();
      rd_chk("ext_status", 5'd12, 32'h0103);
      chk("ext_epc", {2'b0, EPC}, 32'h0000_0abc);

      // eret together with mtc0 Status: IM/IE written, EXL forced low.
      TimerInterrupt = 0; ExtInterrupt = '0;
      ERET = 1; MTC0 = 1; regnum = 5'd12; wr_data = 32'h0000_ff03;
      step();
      ERET = 0; MTC0 = 0;
      rd_chk("eret_mtc0", 5'd12, 32'h0000_ff01);
      chk("eret_mtc0_taken", {31'b0, TakenInterrupt}, 32'h0);

      ERET = 1;
      step();
      ERET = 0;
      rd_chk("eret_noexl", 5'd12, 32'h0000_ff01);

      MTC0 = 1; regnum = 5'd13; wr_data = 32'h0000_ffff;
      step();
      MTC0 = 0;
      rd_chk("cause_ro", 5'd13, 32'h0);
      rd_chk("other_reg", 5'd5, 32'h0);

      MTC0 = 1; regnum = 5'd12; wr_data = 32'hffff_fffc;
      step();
      MTC0 = 0;
      rd_chk("status_mask", 5'd12, 32'h0000_ff00);
      chk("epc_kept", {2'b0, EPC}, 32'h0000_0abc);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
